// File: rtl/pool_serializer.sv
// pool_serializer: captures a WL-bit pooled word and emits it one bit per beat,
// address 0 first, under valid/ready flow control, then pulses oDONE once.
module pool_serializer #(
   parameter int unsigned WL = 5
) (
   input  logic          iCLK,
   input  logic          iRSTn,
   input  logic          iLOAD,
   input  logic [WL-1:0] iDATA,
   input  logic          iREADY,
   output logic          oBUSY,
   output logic          oVALID,
   output logic          oDATA,
   output logic [6:0]    oADDR,
   output logic          oLAST,
   output logic          oDONE
);

   localparam int unsigned CW = 7;
   localparam logic [CW-1:0] LAST_IDX = CW'(WL - 1);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      SEND = 2'b01,
      DONE = 2'b10
   } state_e;

   state_e         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [WL-1:0]  held_q, held_d;
   logic [WL-1:0]  held_shift;

   logic           busy_q, busy_d;
   logic           valid_q, valid_d;
   logic           data_q, data_d;
   logic [CW-1:0]  addr_q, addr_d;
   logic           last_q, last_d;
   logic           done_q, done_d;

   // Next-state, counter and holding-register update, plus next output values
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      held_d     = held_q;
      busy_d     = 1'b0;
      valid_d    = 1'b0;
      data_d     = 1'b0;
      addr_d     = '0;
      last_d     = 1'b0;
      done_d     = 1'b0;
      held_shift = '0;

      case (state_q)
         IDLE: begin
            if (iLOAD) begin
               held_d  = iDATA;
               cnt_d   = '0;
               state_d = SEND;
            end
         end
         SEND: begin
            // valid is implied by being in SEND, so a beat moves on iREADY alone
            if (iREADY) begin
               if (cnt_q == LAST_IDX) begin
                  state_d = DONE;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Outputs are registered, so they are derived from the next state
      held_shift = held_d >> cnt_d;
      busy_d     = (state_d == SEND) || (state_d == DONE);
      done_d     = (state_d == DONE);
      if (state_d == SEND) begin
         valid_d = 1'b1;
         addr_d  = cnt_d;
         data_d  = held_shift[0];
         last_d  = (cnt_d == LAST_IDX);
      end
   end

   // State, datapath and output registers with asynchronous clear
   always_ff @(posedge iCLK or negedge iRSTn) begin
      if (!iRSTn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         held_q  <= '0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         data_q  <= 1'b0;
         addr_q  <= '0;
         last_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         held_q  <= held_d;
         busy_q  <= busy_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         addr_q  <= addr_d;
         last_q  <= last_d;
         done_q  <= done_d;
      end
   end

   assign oBUSY  = busy_q;
   assign oVALID = valid_q;
   assign oDATA  = data_q;
   assign oADDR  = addr_q;
   assign oLAST  = last_q;
   assign oDONE  = done_q;

endmodule

// File: tb/tb_pool_serializer.sv
// Directed bench for pool_serializer: a WL=5 instance driven from a vector
// table plus hand-written reset/throughput sequences, and a WL=1 instance.
module tb_pool_serializer;

   logic clk = 1'b0;
   logic rst_n;

   // WL=5 instance
   logic       load5, ready5;
   logic [4:0] data5;
   logic       busy5, valid5, dat5, last5, done5;
   logic [6:0] addr5;

   // WL=1 instance
   logic       load1, ready1;
   logic [0:0] data1;
   logic       busy1, valid1, dat1, last1, done1;
   logic [6:0] addr1;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   pool_serializer #(.WL(5)) u_dut5 (
      .iCLK(clk), .iRSTn(rst_n), .iLOAD(load5), .iDATA(data5), .iREADY(ready5),
      .oBUSY(busy5), .oVALID(valid5), .oDATA(dat5), .oADDR(addr5),
      .oLAST(last5), .oDONE(done5)
   );

   pool_serializer #(.WL(1)) u_dut1 (
      .iCLK(clk), .iRSTn(rst_n), .iLOAD(load1), .iDATA(data1), .iREADY(ready1),
      .oBUSY(busy1), .oVALID(valid1), .oDATA(dat1), .oADDR(addr1),
      .oLAST(last1), .oDONE(done1)
   );

   // observed outputs packed as {busy, valid, data, addr[6:0], last, done}
   wire logic [11:0] obs5 = {busy5, valid5, dat5, addr5, last5, done5};
   wire logic [11:0] obs1 = {busy1, valid1, dat1, addr1, last1, done1};

   typedef struct {
      logic        load;
      logic [4:0]  data;
      logic        ready;
      logic [11:0] exp;
      string       name;
   } vec_t;

   vec_t tbl[$];

   function automatic logic [11:0] ex(input logic b, input logic v, input logic d,
                                      input int a, input logic l, input logic dn);
      return {b, v, d, 7'(a), l, dn};
   endfunction

   function automatic void add(input string nm, input logic ld, input logic [4:0] dt,
                               input logic rd, input logic [11:0] e);
      vec_t r;
      r.name = nm; r.load = ld; r.data = dt; r.ready = rd; r.exp = e;
      tbl.push_back(r);
   endfunction

   task automatic check(input string nm, input logic [11:0] got, input logic [11:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got {busy,valid,data,addr,last,done}=%b_%b_%b_%0d_%b_%b required %b_%b_%b_%0d_%b_%b",
                  nm, got[11], got[10], got[9], got[8:2], got[1], got[0],
                  exp[11], exp[10], exp[9], exp[8:2], exp[1], exp[0]);
      end
   endtask

   task automatic step5(input logic ld, input logic [4:0] dt, input logic rd);
      @(negedge clk);
      load5 = ld; data5 = dt; ready5 = rd;
      @(posedge clk);
      #1;
   endtask

   logic [11:0] IDLE_O;
   int starts[$];
   logic prev_valid;

   initial begin
      IDLE_O = '0;
      rst_n = 1'b0;
      load5 = 1'b0; data5 = '0; ready5 = 1'b0;
      load1 = 1'b0; data1 = '0; ready1 = 1'b0;

      // basic word 10110, no backpressure
      add("basic_a0", 1, 5'b10110, 1, ex(1,1,0,0,0,0));
      add("basic_a1", 0, 5'b00000, 1, ex(1,1,1,1,0,0));
      add("basic_a2", 0, 5'b00000, 1, ex(1,1,1,2,0,0));
      add("basic_a3", 0, 5'b00000, 1, ex(1,1,0,3,0,0));
      add("basic_a4", 0, 5'b00000, 1, ex(1,1,1,4,1,0));
      add("basic_done", 0, 5'b00000, 1, ex(1,0,0,0,0,1));
      add("basic_idle", 0, 5'b00000, 1, IDLE_O);
      // backpressure at addr 2 for 3 cycles
      add("bp_a0", 1, 5'b10110, 0, ex(1,1,0,0,0,0));
      add("bp_a0_hold", 0, 5'b00000, 0, ex(1,1,0,0,0,0));
      add("bp_a1", 0, 5'b00000, 1, ex(1,1,1,1,0,0));
      add("bp_a2", 0, 5'b00000, 1, ex(1,1,1,2,0,0));
      add("bp_hold1", 0, 5'b00000, 0, ex(1,1,1,2,0,0));
      add("bp_hold2", 0, 5'b00000, 0, ex(1,1,1,2,0,0));
      add("bp_hold3", 0, 5'b00000, 0, ex(1,1,1,2,0,0));
      add("bp_a3", 0, 5'b00000, 1, ex(1,1,0,3,0,0));
      add("bp_a4", 0, 5'b00000, 1, ex(1,1,1,4,1,0));
      add("bp_last_hold", 0, 5'b00000, 0, ex(1,1,1,4,1,0));
      add("bp_done", 0, 5'b00000, 1, ex(1,0,0,0,0,1));
      add("bp_idle", 0, 5'b00000, 0, IDLE_O);
      // loads during SEND and DONE are ignored
      add("ign_a0", 1, 5'b01001, 1, ex(1,1,1,0,0,0));
      add("ign_a1", 1, 5'b11111, 1, ex(1,1,0,1,0,0));
      add("ign_a2", 1, 5'b11111, 1, ex(1,1,0,2,0,0));
      add("ign_a3", 1, 5'b11111, 1, ex(1,1,1,3,0,0));
      add("ign_a4", 1, 5'b11111, 1, ex(1,1,0,4,1,0));
      add("ign_done", 1, 5'b11111, 1, ex(1,0,0,0,0,1));
      add("ign_drop_in_done", 1, 5'b11111, 1, IDLE_O);
      add("new_a0", 1, 5'b11111, 1, ex(1,1,1,0,0,0));
      add("new_a1", 0, 5'b00000, 1, ex(1,1,1,1,0,0));
      add("new_a2", 0, 5'b00000, 1, ex(1,1,1,2,0,0));
      add("new_a3", 0, 5'b00000, 1, ex(1,1,1,3,0,0));
      add("new_a4", 0, 5'b00000, 1, ex(1,1,1,4,1,0));
      add("new_done", 0, 5'b00000, 1, ex(1,0,0,0,0,1));
      add("new_idle", 0, 5'b00000, 1, IDLE_O);

      #12;
      check("reset_wl5", obs5, IDLE_O);
      check("reset_wl1", obs1, IDLE_O);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         step5(tbl[i].load, tbl[i].data, tbl[i].ready);
         check(tbl[i].name, obs5, tbl[i].exp);
      end

      // back-to-back loads: word starts must be WL+2 = 7 cycles apart
      prev_valid = 1'b0;
      @(negedge clk);
      load5 = 1'b1; data5 = 5'b10101; ready5 = 1'b1;
      for (int c = 0; c < 40 && starts.size() < 3; c++) begin
         @(posedge clk);
         #1;
         if (valid5 && !prev_valid && addr5 == 7'd0) starts.push_back(c);
         prev_valid = valid5;
      end
      n_tests++;
      if (starts.size() < 3) begin
         n_fail++;
         $display("FAIL b2b_starts: got %0d word starts required 3 within 40 cycles", starts.size());
      end else begin
         for (int k = 1; k < 3; k++) begin
            n_tests++;
            if (starts[k] - starts[k-1] != 7) begin
               n_fail++;
               $display("FAIL b2b_spacing%0d: got %0d cycles required 7", k, starts[k] - starts[k-1]);
            end
         end
      end
      @(negedge clk);
      load5 = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      check("b2b_drain_idle", obs5, IDLE_O);

      // reset in the middle of a word
      step5(1, 5'b10110, 1);
      check("rst_pre_a0", obs5, ex(1,1,0,0,0,0));
      step5(0, 5'b00000, 1);
      step5(0, 5'b00000, 1);
      step5(0, 5'b00000, 1);
      check("rst_pre_a3", obs5, ex(1,1,0,3,0,0));
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_async_clear", obs5, IDLE_O);
      for (int k = 0; k < 2; k++) begin
         @(posedge clk);
         #1;
         check("rst_held_no_done", obs5, IDLE_O);
      end
      @(negedge clk);
      rst_n = 1'b1;
      load5 = 1'b1; data5 = 5'b10110; ready5 = 1'b1;
      @(posedge clk);
      #1;
      check("rst_first_load_a0", obs5, ex(1,1,0,0,0,0));
      step5(0, 5'b00000, 1);
      check("rst_reload_a1", obs5, ex(1,1,1,1,0,0));

      // WL=1: single beat, addr 0, last
      @(negedge clk);
      load1 = 1'b1; data1 = 1'b1; ready1 = 1'b1;
      @(posedge clk);
      #1;
      check("wl1_beat", obs1, ex(1,1,1,0,1,0));
      @(negedge clk);
      load1 = 1'b0;
      @(posedge clk);
      #1;
      check("wl1_done", obs1, ex(1,0,0,0,0,1));
      @(posedge clk);
      #1;
      check("wl1_idle", obs1, IDLE_O);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
